// File: rtl/mul_rsp_if.sv
// Request/response bundle between the multiplier requesters and the shared multiplier.
// The master modport is the requester side; the slave modport is the multiplier.
interface mul_rsp_if #(
  parameter int unsigned W = 32
);
  logic         en0;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic         en1;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         gnt0;
  logic         gnt1;
  logic [2*W-1:0] out;
  logic         vld;
  logic         id;
  logic         busy;

  modport master (
    output en0, a0, b0, en1, a1, b1,
    input  gnt0, gnt1, out, vld, id, busy
  );

  modport slave (
    input  en0, a0, b0, en1, a1, b1,
    output gnt0, gnt1, out, vld, id, busy
  );
endinterface

// File: rtl/mul_rsp.sv
// Shared unsigned multiplier responder: two requester ports with fixed priority
// (port 0 wins), LAT-cycle pipeline from grant to result, no backpressure.
// Optional conflict counter enabled by defining MUL_RSP_CONFLICT_CNT_EN.
// LAT must be in 1..4.
module mul_rsp #(
  parameter int unsigned LAT = 2,
  parameter int unsigned W   = 32
) (
  input  logic           clk,
  input  logic           reset,
  mul_rsp_if.slave       bus
`ifdef MUL_RSP_CONFLICT_CNT_EN
  ,
  input  logic           cnt_clr,
  output logic [15:0]    conflict_cnt
`endif
);

  logic           acc_v;
  logic           acc_id;
  logic [W-1:0]   acc_a;
  logic [W-1:0]   acc_b;
  logic [2*W-1:0] acc_prod;

  // Tag and product presented to the output register.
  logic           fin_v;
  logic           fin_id;
  logic [2*W-1:0] fin_prod;
  logic           pipe_any;

  logic [2*W-1:0] out_q;
  logic           vld_q;
  logic           id_q;
  logic           busy_q;

  // Fixed-priority grant; gated by reset so nothing is accepted while in reset.
  assign bus.gnt0 = reset & bus.en0;
  assign bus.gnt1 = reset & bus.en1 & ~bus.en0;

  assign acc_v  = bus.gnt0 | bus.gnt1;
  assign acc_id = ~bus.en0;

  // Select winning operands and form the full-width unsigned product.
  always_comb begin
    acc_a = bus.en0 ? bus.a0 : bus.a1;
    acc_b = bus.en0 ? bus.b0 : bus.b1;
    acc_prod = {{W{1'b0}}, acc_a} * {{W{1'b0}}, acc_b};
  end

  // The output register is the last of the LAT stages, so only LAT-1 stages sit in between.
  if (LAT == 1) begin : g_direct
    assign fin_v    = acc_v;
    assign fin_id   = acc_id;
    assign fin_prod = acc_prod;
    assign pipe_any = 1'b0;
  end else begin : g_pipe
    logic [LAT-2:0] v_q;
    logic [LAT-2:0] tid_q;
    logic [2*W-1:0] prod_q [LAT-1];

    // Tag shift register: moves every cycle.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        v_q   <= '0;
        tid_q <= '0;
      end else begin
        v_q[0]   <= acc_v;
        tid_q[0] <= acc_id;
        for (int i = 1; i < int'(LAT) - 1; i++) begin
          v_q[i]   <= v_q[i-1];
          tid_q[i] <= tid_q[i-1];
        end
      end
    end

    // Product stages load only behind a valid tag so idle cycles do not toggle data.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < int'(LAT) - 1; i++) begin
          prod_q[i] <= '0;
        end
      end else begin
        if (acc_v) begin
          prod_q[0] <= acc_prod;
        end
        for (int i = 1; i < int'(LAT) - 1; i++) begin
          if (v_q[i-1]) begin
            prod_q[i] <= prod_q[i-1];
          end
        end
      end
    end

    assign fin_v    = v_q[LAT-2];
    assign fin_id   = tid_q[LAT-2];
    assign fin_prod = prod_q[LAT-2];
    assign pipe_any = |v_q;
  end

  // Output stage: tag every cycle, product only on a valid result so out holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
      vld_q <= 1'b0;
      id_q  <= 1'b0;
    end else begin
      vld_q <= fin_v;
      id_q  <= fin_id;
      if (fin_v) begin
        out_q <= fin_prod;
      end
    end
  end

  // Busy covers every stage including the output stage after this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= acc_v | pipe_any;
    end
  end

  assign bus.out  = out_q;
  assign bus.vld  = vld_q;
  assign bus.id   = id_q;
  assign bus.busy = busy_q;

`ifdef MUL_RSP_CONFLICT_CNT_EN
  logic [15:0] cnt_q;

  // Count cycles where both ports request; clear beats increment, saturate at max.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (bus.en0 && bus.en1 && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule
